// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal register with hold/load/shift/rotate/ASR/clear
// and a saturating shift counter.
// Ports: clk, reset_n (async, active-low), en, mode[2:0], d_par, ser_in_l, ser_in_r,
//        q, ser_out_l, ser_out_r, shift_cnt[CW-1:0], full;
//        q_par is present only when USRG_PARITY_EN is defined.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d_par,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             full
`ifdef USRG_PARITY_EN
    ,
    output logic             q_par
`endif
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_SHL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    cnt_inc;

    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

    // Counter saturates at WIDTH so "full" stays meaningful after extra shifts.
    assign cnt_inc = (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + CW'(1);

    always_comb begin
        q_nxt   = q;
        cnt_nxt = shift_cnt;
        if (en) begin
            unique case (mode)
                M_HOLD: begin
                    q_nxt   = q;
                    cnt_nxt = shift_cnt;
                end
                M_LOAD: begin
                    q_nxt   = d_par;
                    cnt_nxt = '0;
                end
                M_SHR: begin
                    q_nxt   = {ser_in_l, q[WIDTH-1:1]};
                    cnt_nxt = cnt_inc;
                end
                M_SHL: begin
                    q_nxt   = {q[WIDTH-2:0], ser_in_r};
                    cnt_nxt = cnt_inc;
                end
                M_ROR: begin
                    q_nxt   = {q[0], q[WIDTH-1:1]};
                    cnt_nxt = cnt_inc;
                end
                M_ROL: begin
                    q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
                    cnt_nxt = cnt_inc;
                end
                M_ASR: begin
                    q_nxt   = {q[WIDTH-1], q[WIDTH-1:1]};
                    cnt_nxt = cnt_inc;
                end
                M_CLR: begin
                    q_nxt   = RESET_VAL;
                    cnt_nxt = '0;
                end
                default: begin
                    q_nxt   = q;
                    cnt_nxt = shift_cnt;
                end
            endcase
        end
    end

    // full is derived from the next count so it rises on the edge the count saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q         <= RESET_VAL;
            shift_cnt <= '0;
            full      <= 1'b0;
        end else begin
            q         <= q_nxt;
            shift_cnt <= cnt_nxt;
            full      <= (cnt_nxt == CNT_MAX);
        end
    end

`ifdef USRG_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_par <= ^RESET_VAL;
        end else begin
            q_par <= ^q_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg (WIDTH=8).
// Expected values are hand-computed constants.
module tb_univ_shift_reg;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d_par;
    logic       ser_in_l;
    logic       ser_in_r;
    logic [7:0] q;
    logic       ser_out_l;
    logic       ser_out_r;
    logic [3:0] shift_cnt;
    logic       full;
`ifdef USRG_PARITY_EN
    logic       q_par;
`endif

    int total = 0;
    int bad   = 0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .mode      (mode),
        .d_par     (d_par),
        .ser_in_l  (ser_in_l),
        .ser_in_r  (ser_in_r),
        .q         (q),
        .ser_out_l (ser_out_l),
        .ser_out_r (ser_out_r),
        .shift_cnt (shift_cnt),
        .full      (full)
`ifdef USRG_PARITY_EN
        ,
        .q_par     (q_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic [2:0] m);
        en   = e;
        mode = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        mode     = 3'b000;
        d_par    = 8'h00;
        ser_in_l = 1'b0;
        ser_in_r = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_q", 64'(q), 64'h00);
        chk("rst_cnt", 64'(shift_cnt), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
`ifdef USRG_PARITY_EN
        chk("rst_par", 64'(q_par), 64'd0);
`endif
        reset_n = 1'b1;

        // load then asynchronous reset mid-cycle
        d_par = 8'hA5;
        step(1'b1, 3'b001);
        chk("load_a5", 64'(q), 64'hA5);
        step(1'b1, 3'b100);
        chk("ror_a5_cnt", 64'(shift_cnt), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_q", 64'(q), 64'h00);
        chk("async_cnt", 64'(shift_cnt), 64'd0);
        chk("async_full", 64'(full), 64'd0);
        en = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // load then rotate right x8
        d_par = 8'h81;
        step(1'b1, 3'b001);
        chk("load_81", 64'(q), 64'h81);
        chk("load_81_cnt", 64'(shift_cnt), 64'd0);
        step(1'b1, 3'b100);
        chk("ror1_q", 64'(q), 64'hC0);
        chk("ror1_cnt", 64'(shift_cnt), 64'd1);
        for (int i = 0; i < 6; i++) step(1'b1, 3'b100);
        chk("ror7_cnt", 64'(shift_cnt), 64'd7);
        chk("ror7_full", 64'(full), 64'd0);
        step(1'b1, 3'b100);
        chk("ror8_q", 64'(q), 64'h81);
        chk("ror8_cnt", 64'(shift_cnt), 64'd8);
        chk("ror8_full", 64'(full), 64'd1);

        // clear, then SIPO via shift left
        step(1'b1, 3'b111);
        chk("clr_q", 64'(q), 64'h00);
        chk("clr_cnt", 64'(shift_cnt), 64'd0);
        chk("clr_full", 64'(full), 64'd0);
        begin
            logic [7:0] bits;
            bits = 8'b1011_0010;
            for (int i = 7; i >= 1; i--) begin
                ser_in_r = bits[i];
                step(1'b1, 3'b011);
            end
            chk("sipo7_full", 64'(full), 64'd0);
            ser_in_r = bits[0];
            step(1'b1, 3'b011);
        end
        chk("sipo_q", 64'(q), 64'hB2);
        chk("sipo_cnt", 64'(shift_cnt), 64'd8);
        chk("sipo_full", 64'(full), 64'd1);
        ser_in_r = 1'b1;
        step(1'b1, 3'b011);
        chk("sat_q", 64'(q), 64'h65);
        chk("sat_cnt", 64'(shift_cnt), 64'd8);
        chk("sat_full", 64'(full), 64'd1);
        chk("sat_sol", 64'(ser_out_l), 64'd0);
        chk("sat_sor", 64'(ser_out_r), 64'd1);

        // arithmetic shift right
        d_par = 8'h90;
        step(1'b1, 3'b001);
        chk("ld90_full", 64'(full), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b110);
        chk("asr_neg", 64'(q), 64'hF2);
        d_par = 8'h40;
        step(1'b1, 3'b001);
        for (int i = 0; i < 2; i++) step(1'b1, 3'b110);
        chk("asr_pos", 64'(q), 64'h10);
        chk("asr_pos_cnt", 64'(shift_cnt), 64'd2);
        d_par = 8'h80;
        step(1'b1, 3'b001);
        for (int i = 0; i < 8; i++) step(1'b1, 3'b110);
        chk("asr_conv", 64'(q), 64'hFF);

        // enable gating
        d_par = 8'h3C;
        step(1'b1, 3'b001);
        ser_in_l = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 3'b010);
        chk("en0_q", 64'(q), 64'h3C);
        chk("en0_cnt", 64'(shift_cnt), 64'd0);
        step(1'b1, 3'b010);
        chk("en1_q", 64'(q), 64'h9E);
        chk("en1_cnt", 64'(shift_cnt), 64'd1);

        // hold, shift right, rotate left
        step(1'b1, 3'b000);
        chk("hold_q", 64'(q), 64'h9E);
        chk("hold_cnt", 64'(shift_cnt), 64'd1);
        ser_in_l = 1'b0;
        step(1'b1, 3'b010);
        chk("shr_q", 64'(q), 64'h4F);
        chk("shr_cnt", 64'(shift_cnt), 64'd2);
        step(1'b1, 3'b101);
        chk("rol_q", 64'(q), 64'h9E);
        chk("rol_sol", 64'(ser_out_l), 64'd1);

`ifdef USRG_PARITY_EN
        d_par = 8'h07;
        step(1'b1, 3'b001);
        chk("par_07", 64'(q_par), 64'd1);
        ser_in_r = 1'b0;
        step(1'b1, 3'b011);
        chk("par_0e_q", 64'(q), 64'h0E);
        chk("par_0e", 64'(q_par), 64'd1);
        d_par = 8'h03;
        step(1'b1, 3'b001);
        chk("par_03", 64'(q_par), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
